// File: rtl/router_pkg.sv
// -----------------------------------------------------------------------------
// router_pkg
// Shared definitions for the byte output router.
//   BYTE_W     : default data width of one slot
//   slot_state_e : per-slot occupancy state (EMPTY / FULL)
//   sel_width(n) : select code width for n slots, never below 1 bit
// -----------------------------------------------------------------------------
package router_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_e;

  // A single slot still needs a 1-bit select, so clamp at 1.
  function automatic int sel_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/router_slot.sv
// -----------------------------------------------------------------------------
// router_slot
// One output slot: data register plus an EMPTY/FULL state flop.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   i_load     : accepted write targets this slot (already qualified by top)
//   i_rd       : consumer acknowledge
//   i_data     : byte to load
//   o_data     : held data (keeps last value after consumption)
//   o_valid    : slot is FULL
// -----------------------------------------------------------------------------
module router_slot
  import router_pkg::*;
#(
  parameter int WIDTH = BYTE_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic             i_rd,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data,
  output logic             o_valid
);

  slot_state_e      r_state;
  logic [WIDTH-1:0] r_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= SLOT_EMPTY;
      r_data  <= '0;
    end else begin
      case (r_state)
        SLOT_EMPTY: begin
          // A read on an empty slot is simply ignored.
          if (i_load) begin
            r_data  <= i_data;
            r_state <= SLOT_FULL;
          end
        end
        SLOT_FULL: begin
          // Load wins over read: same-cycle write+read passes straight through.
          if (i_load) begin
            r_data <= i_data;
          end else if (i_rd) begin
            r_state <= SLOT_EMPTY;
          end
        end
        default: r_state <= SLOT_EMPTY;
      endcase
    end
  end

  assign o_data  = r_data;
  assign o_valid = (r_state == SLOT_FULL);

endmodule

// File: rtl/byte_output_router.sv
// -----------------------------------------------------------------------------
// byte_output_router
// Steers one byte-wide write port into one of NUM_OUT registered slots.
// Each slot holds its byte with a valid flag until its consumer acknowledges.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   in_data    : byte to route
//   in_sel     : target slot index
//   in_we      : write request
//   in_ready   : addressed slot(s) can accept this cycle (combinational)
//   out_data   : flattened slot data, slot k at [k*WIDTH +: WIDTH]
//   out_valid  : per-slot FULL flag
//   out_rd     : per-slot consumer acknowledge
//   overflow   : sticky rejected-write flag
//   ovf_clr    : synchronous clear of overflow (a same-cycle rejection wins)
// Optional build macro ROUTER_BROADCAST_EN: an all-ones in_sel writes every
// slot at once (for power-of-two NUM_OUT the top slot becomes unreachable).
// -----------------------------------------------------------------------------
module byte_output_router
  import router_pkg::*;
#(
  parameter  int NUM_OUT = 2,
  parameter  int WIDTH   = BYTE_W,
  localparam int SEL_W   = sel_width(NUM_OUT)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [WIDTH-1:0]         in_data,
  input  logic [SEL_W-1:0]         in_sel,
  input  logic                     in_we,
  output logic                     in_ready,
  output logic [NUM_OUT*WIDTH-1:0] out_data,
  output logic [NUM_OUT-1:0]       out_valid,
  input  logic [NUM_OUT-1:0]       out_rd,
  output logic                     overflow,
  input  logic                     ovf_clr
);

  logic [NUM_OUT-1:0] w_hit;
  logic [NUM_OUT-1:0] w_free;
  logic [NUM_OUT-1:0] w_load;
  logic               w_bcast;
  logic               w_ready_addr;
  logic               w_ready_bcast;
  logic               w_accept;
  logic               w_reject;
  logic               r_overflow;

`ifdef ROUTER_BROADCAST_EN
  assign w_bcast = &in_sel;
`else
  assign w_bcast = 1'b0;
`endif

  genvar gi;
  generate
    for (gi = 0; gi < NUM_OUT; gi++) begin : g_slot
      // An out-of-range select matches no slot, so it can never be ready.
      assign w_hit[gi]  = (in_sel == SEL_W'(gi)) && !w_bcast;
      assign w_free[gi] = !out_valid[gi] || out_rd[gi];
      assign w_load[gi] = w_accept && (w_hit[gi] || w_bcast);

      router_slot #(
        .WIDTH (WIDTH)
      ) u_slot (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_load  (w_load[gi]),
        .i_rd    (out_rd[gi]),
        .i_data  (in_data),
        .o_data  (out_data[gi*WIDTH +: WIDTH]),
        .o_valid (out_valid[gi])
      );
    end
  endgenerate

  assign w_ready_addr  = |(w_hit & w_free);
  assign w_ready_bcast = &w_free;
  assign in_ready      = w_bcast ? w_ready_bcast : w_ready_addr;

  assign w_accept = in_we && in_ready;
  assign w_reject = in_we && !in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_overflow <= 1'b0;
    end else if (w_reject) begin
      r_overflow <= 1'b1;
    end else if (ovf_clr) begin
      r_overflow <= 1'b0;
    end
  end

  assign overflow = r_overflow;

endmodule

// File: tb/tb_byte_output_router.sv
// -----------------------------------------------------------------------------
// tb_byte_output_router
// Two instances: NUM_OUT=2 (checked against a behavioural model with directed
// and random traffic) and NUM_OUT=3 (directed out-of-range / broadcast cases).
// Expected results are queued when stimulus is driven and popped one cycle
// later when the outputs are sampled.
// -----------------------------------------------------------------------------
module tb_byte_output_router;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  // NUM_OUT = 2 instance
  logic [7:0]  d2_in;
  logic        d2_sel;
  logic        d2_we;
  logic        d2_ready;
  logic [15:0] d2_out;
  logic [1:0]  d2_valid;
  logic [1:0]  d2_rd;
  logic        d2_ovf;
  logic        d2_clr;

  // NUM_OUT = 3 instance
  logic [7:0]  d3_in;
  logic [1:0]  d3_sel;
  logic        d3_we;
  logic        d3_ready;
  logic [23:0] d3_out;
  logic [2:0]  d3_valid;
  logic [2:0]  d3_rd;
  logic        d3_ovf;
  logic        d3_clr;

  byte_output_router #(.NUM_OUT(2), .WIDTH(8)) u_dut2 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (d2_in),
    .in_sel    (d2_sel),
    .in_we     (d2_we),
    .in_ready  (d2_ready),
    .out_data  (d2_out),
    .out_valid (d2_valid),
    .out_rd    (d2_rd),
    .overflow  (d2_ovf),
    .ovf_clr   (d2_clr)
  );

  byte_output_router #(.NUM_OUT(3), .WIDTH(8)) u_dut3 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (d3_in),
    .in_sel    (d3_sel),
    .in_we     (d3_we),
    .in_ready  (d3_ready),
    .out_data  (d3_out),
    .out_valid (d3_valid),
    .out_rd    (d3_rd),
    .overflow  (d3_ovf),
    .ovf_clr   (d3_clr)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  typedef struct {
    string       tag;
    int          dut;
    logic [31:0] data;
    logic [31:0] valid;
    logic        ovf;
  } exp_t;

  exp_t exp_q[$];

  // Reference model of the NUM_OUT=2 instance
  logic [7:0] m_data [2];
  logic [1:0] m_valid;
  logic       m_ovf;

  task automatic model_reset();
    m_data[0] = 8'h00;
    m_data[1] = 8'h00;
    m_valid   = 2'b00;
    m_ovf     = 1'b0;
  endtask

  task automatic compare_out();
    exp_t e;
    if (exp_q.size() == 0) begin
      check("sb_underflow", 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      if (e.dut == 2) begin
        check({e.tag, "_data"},  {16'h0, d2_out},   e.data);
        check({e.tag, "_valid"}, {30'h0, d2_valid}, e.valid);
        check({e.tag, "_ovf"},   {31'h0, d2_ovf},   {31'h0, e.ovf});
      end else begin
        check({e.tag, "_data"},  {8'h0, d3_out},    e.data);
        check({e.tag, "_valid"}, {29'h0, d3_valid}, e.valid);
        check({e.tag, "_ovf"},   {31'h0, d3_ovf},   {31'h0, e.ovf});
      end
      $display("txn %s: data=0x%0h valid=0x%0h ovf=%0d", e.tag, e.data, e.valid, e.ovf);
    end
  endtask

  task automatic step2(input string tag, input logic we, input logic sel,
                       input logic [7:0] din, input logic [1:0] rd, input logic clr);
    logic ready;
    logic bc;
    exp_t e;
    @(negedge clk);
    d2_we  = we;
    d2_sel = sel;
    d2_in  = din;
    d2_rd  = rd;
    d2_clr = clr;
    bc = 1'b0;
`ifdef ROUTER_BROADCAST_EN
    bc = (sel == 1'b1);
`endif
    if (bc) ready = &(~m_valid | rd);
    else    ready = !m_valid[sel] || rd[sel];
    #1;
    check({tag, "_ready"}, {31'h0, d2_ready}, {31'h0, ready});
    for (int k = 0; k < 2; k++) begin
      if (we && ready && (bc || (int'(sel) == k))) begin
        m_data[k]  = din;
        m_valid[k] = 1'b1;
      end else if (rd[k]) begin
        m_valid[k] = 1'b0;
      end
    end
    if (we && !ready) m_ovf = 1'b1;
    else if (clr)     m_ovf = 1'b0;
    e.tag   = tag;
    e.dut   = 2;
    e.data  = {16'h0, m_data[1], m_data[0]};
    e.valid = {30'h0, m_valid};
    e.ovf   = m_ovf;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    d2_we  = 1'b0;
    d2_rd  = 2'b00;
    d2_clr = 1'b0;
    compare_out();
  endtask

  task automatic step3(input string tag, input logic we, input logic [1:0] sel,
                       input logic [7:0] din, input logic [2:0] rd, input logic clr,
                       input logic exp_ready, input logic [23:0] exp_data,
                       input logic [2:0] exp_valid, input logic exp_ovf);
    exp_t e;
    @(negedge clk);
    d3_we  = we;
    d3_sel = sel;
    d3_in  = din;
    d3_rd  = rd;
    d3_clr = clr;
    #1;
    check({tag, "_ready"}, {31'h0, d3_ready}, {31'h0, exp_ready});
    e.tag   = tag;
    e.dut   = 3;
    e.data  = {8'h0, exp_data};
    e.valid = {29'h0, exp_valid};
    e.ovf   = exp_ovf;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    d3_we  = 1'b0;
    d3_sel = 2'b00;
    d3_rd  = 3'b000;
    d3_clr = 1'b0;
    compare_out();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n  = 1'b0;
    d2_in  = 8'h00; d2_sel = 1'b0; d2_we = 1'b0; d2_rd = 2'b00; d2_clr = 1'b0;
    d3_in  = 8'h00; d3_sel = 2'b00; d3_we = 1'b0; d3_rd = 3'b000; d3_clr = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    check("rst_valid2", {30'h0, d2_valid}, 32'h0);
    check("rst_data2",  {16'h0, d2_out},   32'h0);
    check("rst_ovf2",   {31'h0, d2_ovf},   32'h0);
    rst_n = 1'b1;

    // Preload a slot and raise overflow, then reset mid-cycle.
    step2("pre_fill0", 1'b1, 1'b0, 8'h11, 2'b00, 1'b0);
    step2("pre_rej0",  1'b1, 1'b0, 8'h22, 2'b00, 1'b0);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_rst_valid2", {30'h0, d2_valid}, 32'h0);
    check("async_rst_data2",  {16'h0, d2_out},   32'h0);
    check("async_rst_ovf2",   {31'h0, d2_ovf},   32'h0);
    check("async_rst_valid3", {29'h0, d3_valid}, 32'h0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;

    // Directed traffic on the 2-slot instance.
    step2("wr_a5",    1'b1, 1'b1, 8'hA5, 2'b00, 1'b0);
    step2("rd1",      1'b0, 1'b0, 8'h00, 2'b10, 1'b0);
    step2("fill0",    1'b1, 1'b0, 8'h11, 2'b00, 1'b0);
    step2("rej0",     1'b1, 1'b0, 8'h22, 2'b00, 1'b0);
    step2("clr",      1'b0, 1'b0, 8'h00, 2'b00, 1'b1);
    step2("pass0",    1'b1, 1'b0, 8'h33, 2'b01, 1'b0);
    step2("rej_clr",  1'b1, 1'b0, 8'h44, 2'b00, 1'b1);
    step2("clr2",     1'b0, 1'b0, 8'h00, 2'b00, 1'b1);
    step2("rd_empty", 1'b0, 1'b0, 8'h00, 2'b10, 1'b0);
    step2("wr1_rd0",  1'b1, 1'b1, 8'h66, 2'b01, 1'b0);

    // Random traffic against the model.
    for (int i = 0; i < 40; i++) begin
      step2($sformatf("rnd%0d", i),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            8'($urandom_range(0, 255)), 2'($urandom_range(0, 3)),
            ($urandom_range(0, 7) == 0));
    end

    // 3-slot instance: in-range write, consume, then the all-ones select.
    step3("d3_wr2", 1'b1, 2'd2, 8'h44, 3'b000, 1'b0, 1'b1, 24'h440000, 3'b100, 1'b0);
    step3("d3_rd2", 1'b0, 2'd0, 8'h00, 3'b100, 1'b0, 1'b1, 24'h440000, 3'b000, 1'b0);
`ifdef ROUTER_BROADCAST_EN
    step3("d3_bc",     1'b1, 2'd3, 8'h5A, 3'b000, 1'b0, 1'b1, 24'h5A5A5A, 3'b111, 1'b0);
    step3("d3_bc_rej", 1'b1, 2'd3, 8'hA5, 3'b000, 1'b0, 1'b0, 24'h5A5A5A, 3'b111, 1'b1);
`else
    step3("d3_sel3",   1'b1, 2'd3, 8'h77, 3'b000, 1'b0, 1'b0, 24'h440000, 3'b000, 1'b1);
    step3("d3_clr",    1'b0, 2'd0, 8'h00, 3'b000, 1'b1, 1'b1, 24'h440000, 3'b000, 1'b0);
`endif

    check("sb_drained", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/byte_output_router.md
Name: byte_output_router

Overview:
- Output selector: one byte-wide write port steered to one of NUM_OUT registered output slots by a select code.
- Each slot holds its byte with a valid flag until its consumer acknowledges it.
- Sits on the write side of the byte bus, opposite the input selector. Feeds registers, RAM write ports and output pins.

Parameters:
- NUM_OUT, 2, number of output slots (2..16).
- WIDTH, 8, data width per slot.
- SEL_W, $clog2(NUM_OUT) (min 1), select code width; derived, not overridden.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_data  input  WIDTH  byte to route.
- in_sel  input  SEL_W  target slot index.
- in_we  input  1  write request.
- in_ready  output  1  the addressed slot can accept a write this cycle.
- out_data  output  NUM_OUT*WIDTH  flattened slot registers; slot k is bits [k*WIDTH +: WIDTH].
- out_valid  output  NUM_OUT  slot k holds unconsumed data.
- out_rd  input  NUM_OUT  consumer k acknowledges slot k.
- overflow  output  1  sticky error flag.
- ovf_clr  input  1  synchronous clear of overflow.

Behaviour:
- Reset (async, rst_n=0): out_data all 0, out_valid all 0, overflow 0. Writes are ignored while reset is asserted. Reset mid-transfer discards all slot contents.
- Each slot runs a 2-state FSM, EMPTY/FULL, reflected directly on out_valid[k].
- in_ready is combinational: (in_sel < NUM_OUT) && (slot[in_sel]==EMPTY || out_rd[in_sel]).
- Accepted write (in_we && in_ready):
  - slot[in_sel] data <= in_data at the next rising edge.
  - out_valid[in_sel] <= 1.
  - Latency: 1 cycle from request to out_data/out_valid.
- Read: out_rd[k] with out_valid[k]=1 sets slot k to EMPTY at the next edge. Data stays unchanged (holds the last value).
- Read on an EMPTY slot is ignored; no error.
- Write and read of the same slot in the same cycle: new data is loaded and out_valid stays 1 (pass-through, no bubble).
- Write and read of different slots in the same cycle: both take effect independently.
- Rejected write (in_we && !in_ready), i.e. target FULL without out_rd, or in_sel >= NUM_OUT:
  - data is dropped and the slot is unchanged;
  - overflow <= 1 at the next edge.
- overflow clears only on ovf_clr or reset. If ovf_clr and a new rejection occur in the same cycle, set wins (overflow=1).
- Only the addressed slot can change by a write. Other slots hold.
- in_sel is don't-care when in_we=0.

Optional Feature:
- Macro ROUTER_BROADCAST_EN.
- Defined: an in_sel of all ones is a broadcast when it is >= NUM_OUT (or when NUM_OUT is a power of two, all ones is reserved and slot NUM_OUT-1 becomes unreachable).
  - in_ready is 1 only if every slot is EMPTY or being read that cycle.
  - An accepted broadcast loads in_data into all slots and sets all out_valid.
  - A rejected broadcast sets overflow and changes no slot.
- Undefined: all-ones is an ordinary index. If it is out of range it is rejected with overflow, as above.

Decomposition:
- Package router_pkg:
  - localparam BYTE_W=8;
  - slot state enum {SLOT_EMPTY, SLOT_FULL};
  - function sel_width(n) returning max(1, clog2(n)).
- Sub-module router_slot: one slot (data register, state flop, load/consume logic), generate-instantiated NUM_OUT times.
- Top level holds select decode, in_ready mux, overflow flop and the broadcast logic.

Test Plan:
- Reset with out_data preloaded: assert rst_n=0 mid-cycle -> out_valid=0, out_data=0, overflow=0 immediately, without waiting for a clock edge.
- Write 0xA5 to sel=1, NUM_OUT=2 -> next cycle out_valid=2'b10, slot1=0xA5, slot0=0x00. Pulse out_rd[1] -> out_valid=0, slot1 still 0xA5.
- Slot0 FULL with 0x11; write 0x22 to sel=0 without out_rd -> in_ready=0, slot0 stays 0x11, overflow=1. Pulse ovf_clr -> overflow=0.
- Slot0 FULL with 0x11; write 0x33 with out_rd[0]=1 in the same cycle -> in_ready=1, slot0=0x33, out_valid[0] remains 1, overflow=0.
- NUM_OUT=3; write to sel=3 -> in_ready=0, no slot changes, overflow=1.
- With ROUTER_BROADCAST_EN, NUM_OUT=3, all slots EMPTY; write 0x5A with sel=2'b11 -> all three slots=0x5A, out_valid=3'b111. Repeat the broadcast with no reads -> rejected, overflow=1.
